alu_multicycle: RTL and testbench

Parametrised, handshaked successor to the single-cycle datapath ALU. It adds the RV32M multiply and divide operations, implemented as iterative radix-2 engines, to the existing base operation set. It sits in the execute stage, and the pipeline stalls on `in_ready` = 0. Base operations complete in one cycle. MUL/DIV-class operations take DATA_WIDTH iteration cycles.

---
 rtl/alu_multicycle.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// ----------------------------------------------------------------------------
// alu_multicycle
//   Execute-stage ALU with a valid/ready handshake. Base operations finish in
//   one cycle. RV32M multiply/divide run on iterative radix-2 engines that
//   take DATA_WIDTH cycles. Divide-by-zero and signed overflow bypass the
//   engine and finish in one cycle.
//
//   Opcode map (Operation[4:0], any wider bits must be zero):
//     0_0000 AND   0_0001 OR    0_0010 ADD   0_0011 XOR   0_0100 SUB
//     0_0101 SLT   0_0110 SLL   0_0111 SRL   0_1001 SRA
//     0_1000 EQ    0_1010 GE    0_1011 SLTU  0_1100 NE
//     1_0000 MUL   1_0001 MULH  1_0010 MULHSU 1_0011 MULHU
//     1_0100 DIV   1_0101 DIVU  1_0110 REM    1_0111 REMU
//     anything else -> 0 with base-op latency
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   operation request
//   in_ready   high only in IDLE; accept on in_valid & in_ready
//   Operation  operation code, sampled on acceptance
//   SrcA/SrcB  operands, sampled on acceptance
//   flush      synchronous abort of the operation in flight
//   out_valid  ALUResult is valid
//   out_ready  consumer takes the result
//   ALUResult  registered result
//   busy       high while the multiply or divide engine iterates
// ----------------------------------------------------------------------------
module alu_multicycle #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     busy
);

    localparam int unsigned W   = DATA_WIDTH;
    localparam int unsigned SHW = $clog2(DATA_WIDTH);
    localparam int unsigned PW  = 2 * DATA_WIDTH;

    localparam logic [SHW-1:0] LAST_ITER = SHW'(W - 1);
    localparam logic [W-1:0]   MOST_NEG  = {1'b1, {(W-1){1'b0}}};

    localparam logic [4:0] OP_AND  = 5'b0_0000;
    localparam logic [4:0] OP_OR   = 5'b0_0001;
    localparam logic [4:0] OP_ADD  = 5'b0_0010;
    localparam logic [4:0] OP_XOR  = 5'b0_0011;
    localparam logic [4:0] OP_SUB  = 5'b0_0100;
    localparam logic [4:0] OP_SLT  = 5'b0_0101;
    localparam logic [4:0] OP_SLL  = 5'b0_0110;
    localparam logic [4:0] OP_SRL  = 5'b0_0111;
    localparam logic [4:0] OP_EQ   = 5'b0_1000;
    localparam logic [4:0] OP_SRA  = 5'b0_1001;
    localparam logic [4:0] OP_GE   = 5'b0_1010;
    localparam logic [4:0] OP_SLTU = 5'b0_1011;
    localparam logic [4:0] OP_NE   = 5'b0_1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;

    // Iteration datapath
    logic [PW-1:0]  prod;
    logic [PW-1:0]  mcand;
    logic [W-1:0]   mplier;
    logic [W-1:0]   rem;
    logic [W-1:0]   quo;
    logic [W-1:0]   dvsr;
    logic [SHW-1:0] count;
    logic           neg_main;   // negate product / quotient at the end
    logic           neg_rem;    // negate remainder at the end
    logic           sel_alt;    // pick high half (mul) or remainder (div)

    // Request decode
    logic [4:0]     op;
    logic           op_ext_zero;
    logic           is_m;
    logic           is_mul;
    logic           is_div;
    logic           a_sgn;
    logic           b_sgn;
    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic           div_zero;
    logic           div_ovf;
    logic           div_fast;
    logic [W-1:0]   fast_res;
    logic [SHW-1:0] shamt;
    logic [W-1:0]   base_res;

    // Per-iteration step values
    logic [PW-1:0]  prod_step;
    logic [PW-1:0]  prod_fin;
    logic [W-1:0]   mul_res;
    logic [W:0]     div_trial;
    logic           div_ge;
    logic [W-1:0]   rem_step;
    logic [W-1:0]   quo_step;
    logic [W-1:0]   quo_fin;
    logic [W-1:0]   rem_fin;
    logic [W-1:0]   div_res;

    assign in_ready = (state == IDLE);
    assign busy     = (state == MUL) || (state == DIV);

    // Opcode and operand-sign decode for an incoming request
    always_comb begin
        op          = Operation[4:0];
        op_ext_zero = ((Operation >> 5) == '0);
        is_m        = op_ext_zero && op[4] && !op[3];
        is_mul      = is_m && !op[2];
        is_div      = is_m && op[2];

        // MUL/MULH/MULHSU treat A as signed, MUL/MULH treat B as signed;
        // DIV/REM (op[0] == 0) are signed on both operands.
        if (is_mul) begin
            a_sgn = (op[1:0] != 2'b11);
            b_sgn = !op[1];
        end else begin
            a_sgn = !op[0];
            b_sgn = !op[0];
        end

        a_neg = a_sgn && SrcA[W-1];
        b_neg = b_sgn && SrcB[W-1];
        a_mag = a_neg ? -SrcA : SrcA;
        b_mag = b_neg ? -SrcB : SrcB;

        div_zero = (SrcB == '0);
        div_ovf  = !op[0] && (SrcA == MOST_NEG) && (SrcB == '1);
        div_fast = div_zero || div_ovf;

        // op[1] selects the remainder result of a divide
        if (op[1]) begin
            fast_res = div_zero ? SrcA : '0;
        end else begin
            fast_res = div_zero ? '1 : SrcA;
        end
    end

    // Single-cycle base operations
    always_comb begin
        shamt    = SrcB[SHW-1:0];
        base_res = '0;
        case (op)
            OP_AND:  base_res = SrcA & SrcB;
            OP_OR:   base_res = SrcA | SrcB;
            OP_ADD:  base_res = SrcA + SrcB;
            OP_XOR:  base_res = SrcA ^ SrcB;
            OP_SUB:  base_res = SrcA - SrcB;
            OP_SLT:  base_res = W'($signed(SrcA) < $signed(SrcB));
            OP_SLL:  base_res = SrcA << shamt;
            OP_SRL:  base_res = SrcA >> shamt;
            OP_SRA:  base_res = $signed(SrcA) >>> shamt;
            OP_EQ:   base_res = W'(SrcA == SrcB);
            OP_NE:   base_res = W'(SrcA != SrcB);
            OP_GE:   base_res = W'($signed(SrcA) >= $signed(SrcB));
            OP_SLTU: base_res = W'(SrcA < SrcB);
            default: base_res = '0;
        endcase
        if (!op_ext_zero) begin
            base_res = '0;
        end
    end

    // One shift-add step and one restoring-divide step, plus final sign fix
    always_comb begin
        prod_step = prod + (mplier[0] ? mcand : '0);
        prod_fin  = neg_main ? -prod_step : prod_step;
        mul_res   = sel_alt ? prod_fin[PW-1:W] : prod_fin[W-1:0];

        // Shift the next dividend bit into the partial remainder and try
        // subtracting the divisor; the dividend register fills with quotient.
        div_trial = {rem, quo[W-1]};
        div_ge    = (div_trial >= {1'b0, dvsr});
        rem_step  = div_ge ? W'(div_trial - {1'b0, dvsr}) : div_trial[W-1:0];
        quo_step  = {quo[W-2:0], div_ge};
        quo_fin   = neg_main ? -quo_step : quo_step;
        rem_fin   = neg_rem ? -rem_step : rem_step;
        div_res   = sel_alt ? rem_fin : quo_fin;
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            ALUResult <= '0;
            prod      <= '0;
            mcand     <= '0;
            mplier    <= '0;
            rem       <= '0;
            quo       <= '0;
            dvsr      <= '0;
            count     <= '0;
            neg_main  <= 1'b0;
            neg_rem   <= 1'b0;
            sel_alt   <= 1'b0;
        end else if (flush) begin
            // Abort: result register keeps its last value
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_mul) begin
                            state    <= MUL;
                            prod     <= '0;
                            mcand    <= {{W{1'b0}}, a_mag};
                            mplier   <= b_mag;
                            neg_main <= a_neg ^ b_neg;
                            sel_alt  <= (op[1:0] != 2'b00);
                            count    <= '0;
                        end else if (is_div && !div_fast) begin
                            state    <= DIV;
                            rem      <= '0;
                            quo      <= a_mag;
                            dvsr     <= b_mag;
                            neg_main <= a_neg ^ b_neg;
                            neg_rem  <= a_neg;
                            sel_alt  <= op[1];
                            count    <= '0;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            ALUResult <= is_div ? fast_res : base_res;
                        end
                    end
                end
                MUL: begin
                    prod   <= prod_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + SHW'(1);
                    if (count == LAST_ITER) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        ALUResult <= mul_res;
                    end
                end
                DIV: begin
                    rem   <= rem_step;
                    quo   <= quo_step;
                    count <= count + SHW'(1);
                    if (count == LAST_ITER) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        ALUResult <= div_res;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// ----------------------------------------------------------------------------
// tb_alu_multicycle
//   Self-checking bench for alu_multicycle (DATA_WIDTH 32). Expected results
//   and latencies are queued when a request is driven and popped when the
//   result appears.
// ----------------------------------------------------------------------------
module tb_alu_multicycle;

    localparam logic [4:0] OP_AND    = 5'b0_0000;
    localparam logic [4:0] OP_OR     = 5'b0_0001;
    localparam logic [4:0] OP_ADD    = 5'b0_0010;
    localparam logic [4:0] OP_XOR    = 5'b0_0011;
    localparam logic [4:0] OP_SUB    = 5'b0_0100;
    localparam logic [4:0] OP_SLT    = 5'b0_0101;
    localparam logic [4:0] OP_SLL    = 5'b0_0110;
    localparam logic [4:0] OP_SRL    = 5'b0_0111;
    localparam logic [4:0] OP_EQ     = 5'b0_1000;
    localparam logic [4:0] OP_SRA    = 5'b0_1001;
    localparam logic [4:0] OP_GE     = 5'b0_1010;
    localparam logic [4:0] OP_SLTU   = 5'b0_1011;
    localparam logic [4:0] OP_NE     = 5'b0_1100;
    localparam logic [4:0] OP_UNDEF  = 5'b0_1111;
    localparam logic [4:0] OP_MUL    = 5'b1_0000;
    localparam logic [4:0] OP_MULH   = 5'b1_0001;
    localparam logic [4:0] OP_MULHSU = 5'b1_0010;
    localparam logic [4:0] OP_MULHU  = 5'b1_0011;
    localparam logic [4:0] OP_DIV    = 5'b1_0100;
    localparam logic [4:0] OP_DIVU   = 5'b1_0101;
    localparam logic [4:0] OP_REM    = 5'b1_0110;
    localparam logic [4:0] OP_REMU   = 5'b1_0111;

    localparam int TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        busy;

    typedef struct {
        logic [31:0] val;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    alu_multicycle dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model for the M-extension operations
    function automatic logic [31:0] model_m(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        logic [31:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = '0;
        case (op)
            OP_MUL:    begin p = ua * ub;              r = p[31:0];  end
            OP_MULH:   begin p = sa * sb;              r = p[63:32]; end
            OP_MULHSU: begin p = sa * longint'(ub);    r = p[63:32]; end
            OP_MULHU:  begin p = ua * ub;              r = p[63:32]; end
            OP_DIV:    r = 32'($signed(a) / $signed(b));
            OP_DIVU:   r = a / b;
            OP_REM:    r = 32'($signed(a) % $signed(b));
            OP_REMU:   r = a % b;
            default:   r = '0;
        endcase
        return r;
    endfunction

    // Drive one request; returns #1 after the acceptance edge
    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        Operation = 5'($urandom);
        SrcA      = $urandom;
        SrcB      = $urandom;
    endtask

    // Wait for out_valid; lat counts from the acceptance edge (1 = next cycle)
    task automatic wait_result(output logic [31:0] res, output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = ALUResult;
        if (out_valid !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout out_valid: got 0 required 1 within %0d cycles", TIMEOUT);
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
        send(op, a, b);
        wait_result(res, lat);
        release_result();
    endtask

    task automatic test_reset();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b required 0", out_valid); end
        n_checks++;
        if (ALUResult !== 32'd0) begin n_fail++; $display("FAIL reset ALUResult: got %h required 0", ALUResult); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b required 0", busy); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_base_ops();
        logic [4:0]  ops [10] = '{OP_AND, OP_SLT, OP_SLTU, OP_SLL, OP_SRL,
                                  OP_EQ, OP_NE, OP_GE, OP_GE, OP_SUB};
        logic [31:0] as  [10] = '{32'h0000_F0F0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000,
                                  32'd5, 32'd5, 32'hFFFF_FFFF, 32'd3, 32'd9};
        logic [31:0] bs  [10] = '{32'h0000_FF00, 32'd1, 32'd1, 32'h0000_003F, 32'd4,
                                  32'd5, 32'd5, 32'd1, 32'd3, 32'd4};
        logic [31:0] ev  [10] = '{32'h0000_F000, 32'd1, 32'd0, 32'h8000_0000, 32'h0800_0000,
                                  32'd1, 32'd0, 32'd0, 32'd1, 32'd5};
        logic [31:0] res;
        int          lat;
        exp_t        e;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(exp_t'{ev[i], 1});
            run(ops[i], as[i], bs[i], res, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (res !== e.val) begin n_fail++; $display("FAIL base[%0d] op=%h result: got %h required %h", i, ops[i], res, e.val); end
            n_checks++;
            if (lat !== e.lat) begin n_fail++; $display("FAIL base[%0d] latency: got %0d required %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  ops [4] = '{OP_ADD, OP_XOR, OP_SUB, OP_OR};
        logic [31:0] as  [4] = '{32'h10, 32'hF0F0, 32'd5, 32'hA0};
        logic [31:0] bs  [4] = '{32'h20, 32'h0FF0, 32'd7, 32'h0B};
        logic [31:0] ev  [4] = '{32'h30, 32'hFF00, 32'hFFFF_FFFE, 32'hAB};
        exp_t        e;
        int          t_prev;
        t_prev = 0;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            Operation = ops[i];
            SrcA      = as[i];
            SrcB      = bs[i];
            in_valid  = 1'b1;
            exp_q.push_back(exp_t'{ev[i], 2});
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || ALUResult !== e.val) begin
                n_fail++;
                $display("FAIL b2b[%0d] result: got valid=%b %h required valid=1 %h", i, out_valid, ALUResult, e.val);
            end
            if (i > 0) begin
                n_checks++;
                if (cyc - t_prev !== e.lat) begin n_fail++; $display("FAIL b2b[%0d] interval: got %0d required %0d", i, cyc - t_prev, e.lat); end
            end
            t_prev = cyc;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b idle: got in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_mul_high();
        logic [4:0]  ops [3] = '{OP_MULH, OP_MULHSU, OP_MULHU};
        logic [31:0] as  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ev  [3] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        logic [31:0] res;
        int          lat;
        exp_t        e;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(exp_t'{ev[i], 33});
            run(ops[i], as[i], bs[i], res, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (res !== e.val) begin n_fail++; $display("FAIL mulhi[%0d] result: got %h required %h", i, res, e.val); end
            n_checks++;
            if (lat !== e.lat) begin n_fail++; $display("FAIL mulhi[%0d] latency: got %0d required %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_div();
        logic [4:0]  ops [4] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
        logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] ev  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        logic [31:0] res;
        int          lat;
        exp_t        e;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exp_t'{ev[i], 33});
            run(ops[i], as[i], bs[i], res, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (res !== e.val) begin n_fail++; $display("FAIL div[%0d] result: got %h required %h", i, res, e.val); end
            n_checks++;
            if (lat !== e.lat) begin n_fail++; $display("FAIL div[%0d] latency: got %0d required %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_div_fast();
        logic [4:0]  ops [6] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIV, OP_REM};
        logic [31:0] as  [6] = '{32'd7, 32'd7, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFFB};
        logic [31:0] bs  [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] ev  [6] = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
        logic [31:0] res;
        int          lat;
        exp_t        e;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(exp_t'{ev[i], 1});
            run(ops[i], as[i], bs[i], res, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (res !== e.val) begin n_fail++; $display("FAIL divfast[%0d] result: got %h required %h", i, res, e.val); end
            n_checks++;
            if (lat !== e.lat) begin n_fail++; $display("FAIL divfast[%0d] latency: got %0d required %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        int          lat;
        exp_t        e;
        exp_q.push_back(exp_t'{32'd42, 33});
        send(OP_MUL, 32'd6, 32'd7);
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mul start: got busy=%b in_ready=%b required 1 0", busy, in_ready);
        end
        wait_result(res, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (res !== e.val) begin n_fail++; $display("FAIL mul 6x7 result: got %h required %h", res, e.val); end
        n_checks++;
        if (lat !== e.lat) begin n_fail++; $display("FAIL mul 6x7 latency: got %0d required %0d", lat, e.lat); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mul done busy: got %b required 0", busy); end
        @(negedge clk);
        Operation = OP_ADD;
        SrcA      = 32'd1;
        SrcB      = 32'd1;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || ALUResult !== 32'd42 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: got valid=%b res=%h in_ready=%b required 1 0000002a 0",
                         i, out_valid, ALUResult, in_ready);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold release: got valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold stray accept: got valid=%b required 0", out_valid); end
    endtask

    task automatic test_random_m();
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        exp_t        e;
        for (int i = 0; i < 12; i++) begin
            op = {2'b10, 3'($urandom_range(0, 7))};
            a  = $urandom;
            b  = $urandom;
            if (i % 3 == 0) b = b >> $urandom_range(8, 28);
            if (b == 32'd0) b = 32'd3;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            exp_q.push_back(exp_t'{model_m(op, a, b), 33});
            run(op, a, b, res, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (res !== e.val) begin
                n_fail++;
                $display("FAIL rand[%0d] op=%h a=%h b=%h result: got %h required %h", i, op, a, b, res, e.val);
            end
            n_checks++;
            if (lat !== e.lat) begin n_fail++; $display("FAIL rand[%0d] latency: got %0d required %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_reset_mid_div();
        logic [31:0] res;
        int          lat;
        exp_t        e;
        send(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (4) @(posedge clk);
        #2;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL mid-div busy: got %b required 1", busy); end
        reset = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid-div reset out_valid: got %b required 0", out_valid); end
        n_checks++;
        if (ALUResult !== 32'd0) begin n_fail++; $display("FAIL mid-div reset ALUResult: got %h required 0", ALUResult); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid-div reset in_ready: got %b required 1", in_ready); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mid-div reset busy: got %b required 0", busy); end
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(exp_t'{32'd12, 1});
        run(OP_ADD, 32'd7, 32'd5, res, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (res !== e.val) begin n_fail++; $display("FAIL post-reset add result: got %h required %h", res, e.val); end
        n_checks++;
        if (lat !== e.lat) begin n_fail++; $display("FAIL post-reset add latency: got %0d required %0d", lat, e.lat); end
    endtask

    task automatic test_flush();
        logic [4:0]  ops [3] = '{OP_SLTU, OP_SRA, OP_UNDEF};
        logic [31:0] as  [3] = '{32'd1, 32'h8000_0000, 32'h1234_5678};
        logic [31:0] bs  [3] = '{32'hFFFF_FFFF, 32'd4, 32'h0000_0F0F};
        logic [31:0] ev  [3] = '{32'd1, 32'hF800_0000, 32'd0};
        logic [31:0] res;
        int          lat;
        exp_t        e;
        bit          seen;
        exp_q.push_back(exp_t'{32'h0000_00F0, 1});
        run(OP_AND, 32'h0000_F0F0, 32'h0000_00FF, res, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (res !== e.val) begin n_fail++; $display("FAIL flush setup result: got %h required %h", res, e.val); end

        send(OP_DIVU, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush idle: got in_ready=%b busy=%b valid=%b required 1 0 0", in_ready, busy, out_valid);
        end
        n_checks++;
        if (ALUResult !== 32'h0000_00F0) begin n_fail++; $display("FAIL flush hold ALUResult: got %h required 000000f0", ALUResult); end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL flush out_valid rose: got 1 required 0"); end

        @(negedge clk);
        Operation = OP_ADD;
        SrcA      = 32'd3;
        SrcB      = 32'd4;
        in_valid  = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush blocks accept: got valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end

        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(exp_t'{ev[i], 1});
            run(ops[i], as[i], bs[i], res, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (res !== e.val) begin n_fail++; $display("FAIL post-flush[%0d] op=%h result: got %h required %h", i, ops[i], res, e.val); end
            n_checks++;
            if (lat !== e.lat) begin n_fail++; $display("FAIL post-flush[%0d] latency: got %0d required %0d", i, lat, e.lat); end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        Operation = '0;
        SrcA      = '0;
        SrcB      = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b0;

        test_base_ops();
        test_back_to_back();
        test_mul_high();
        test_div();
        test_div_fast();
        test_backpressure();
        test_random_m();
        test_reset_mid_div();
        test_flush();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
